// File: rtl/image_pkg.sv
// -----------------------------------------------------------------------------
// image_pkg
// Shared definitions for the frame output path:
//   - state_e        : frame controller states (IDLE / RUN / DONE)
//   - DEF_IMG_WIDTH  : default output pixels per line
//   - DEF_IMG_HEIGHT : default output lines per frame
//   - cnt_width()    : counter width for a dimension ($clog2, never below 1)
// -----------------------------------------------------------------------------
package image_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_IMG_WIDTH  = 510;
    localparam int DEF_IMG_HEIGHT = 510;

    // A dimension of 1 still needs a 1-bit counter to keep the vectors legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : image_pkg

// File: rtl/frame_output_ctrl.sv
// -----------------------------------------------------------------------------
// frame_output_ctrl
// Gates the pixel stream from the output FIFO to the DMA for exactly one frame
// per start request, marking line ends and the last pixel of the frame, and
// pulsing an interrupt when the frame completes.
//
// Parameters:
//   IMG_WIDTH   pixels per line (2..4096)
//   IMG_HEIGHT  lines per frame (1..4096)
//
// Ports:
//   axi_clk        in   clock (rising edge)
//   axi_reset_n    in   asynchronous active-low reset
//   i_start        in   single-cycle frame start request (IDLE only)
//   i_abort        in   single-cycle abort request (RUN only)
//   i_data_valid   in   FIFO-side valid
//   i_data[7:0]    in   FIFO-side pixel
//   o_data_ready   out  FIFO-side ready (i_data_ready passed through in RUN)
//   o_data_valid   out  DMA-side valid (i_data_valid passed through in RUN)
//   o_data[7:0]    out  DMA-side pixel
//   i_data_ready   in   DMA-side ready
//   o_data_last    out  final pixel of the frame
//   o_line_end     out  final pixel of each line
//   o_busy         out  high while in RUN
//   o_intr         out  one-cycle frame-done pulse
//   o_frame_cnt    out  completed-frame count (FRAME_OUTPUT_CTRL_FRAME_CNT_EN only)
//
// Build option:
//   FRAME_OUTPUT_CTRL_FRAME_CNT_EN  adds the 16-bit completed-frame counter.
// -----------------------------------------------------------------------------
module frame_output_ctrl
    import image_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic        axi_clk,
    input  logic        axi_reset_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_data_valid,
    input  logic [7:0]  i_data,
    output logic        o_data_ready,
    output logic        o_data_valid,
    output logic [7:0]  o_data,
    input  logic        i_data_ready,
    output logic        o_data_last,
    output logic        o_line_end,
    output logic        o_busy,
    output logic        o_intr
`ifdef FRAME_OUTPUT_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

    state_e           state_q;
    logic             busy_q;
    logic             intr_q;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
`ifdef FRAME_OUTPUT_CTRL_FRAME_CNT_EN
    logic [15:0]      frame_cnt_q;
`endif

    logic xfer;
    logic line_end;
    logic last_pix;

    // Handshake and position decode; busy_q mirrors state_q == ST_RUN.
    always_comb begin
        xfer     = busy_q & i_data_valid & i_data_ready;
        line_end = busy_q && (col_q == COL_MAX);
        last_pix = line_end && (row_q == ROW_MAX);

        col_d = col_q;
        row_d = row_q;
        if (xfer) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            intr_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
`ifdef FRAME_OUTPUT_CTRL_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            intr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Completion is checked before abort so a coincident
                    // abort cannot swallow the frame-done interrupt.
                    if (xfer && last_pix) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        intr_q  <= 1'b1;
                        col_q   <= '0;
                        row_q   <= '0;
`ifdef FRAME_OUTPUT_CTRL_FRAME_CNT_EN
                        frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
                    end else if (i_abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        col_q   <= '0;
                        row_q   <= '0;
                    end else begin
                        col_q <= col_d;
                        row_q <= row_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    col_q   <= '0;
                    row_q   <= '0;
                end
            endcase
        end
    end

    // Stream is a zero-latency pass-through while busy and fully closed
    // otherwise, so upstream data is held in the FIFO, never dropped.
    assign o_data_valid = busy_q & i_data_valid;
    assign o_data_ready = busy_q & i_data_ready;
    assign o_data       = busy_q ? i_data : 8'h00;
    assign o_line_end   = line_end;
    assign o_data_last  = last_pix;
    assign o_busy       = busy_q;
    assign o_intr       = intr_q;
`ifdef FRAME_OUTPUT_CTRL_FRAME_CNT_EN
    assign o_frame_cnt  = frame_cnt_q;
`endif

endmodule : frame_output_ctrl

// File: tb/tb_frame_output_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_output_ctrl
// Self-checking bench for frame_output_ctrl with a 4x2 frame. Expected pixels
// and their line-end / last flags are queued when a pixel is offered and
// compared when the DUT completes the transfer.
// Build option honoured: FRAME_OUTPUT_CTRL_FRAME_CNT_EN.
// -----------------------------------------------------------------------------
module tb_frame_output_ctrl;

    localparam int W = 4;
    localparam int H = 2;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n;
    logic        i_start;
    logic        i_abort;
    logic        i_data_valid;
    logic [7:0]  i_data;
    logic        o_data_ready;
    logic        o_data_valid;
    logic [7:0]  o_data;
    logic        i_data_ready;
    logic        o_data_last;
    logic        o_line_end;
    logic        o_busy;
    logic        o_intr;
`ifdef FRAME_OUTPUT_CTRL_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    always #5 axi_clk = ~axi_clk;

    frame_output_ctrl #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_reset_n  (axi_reset_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_data_valid (i_data_valid),
        .i_data       (i_data),
        .o_data_ready (o_data_ready),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .i_data_ready (i_data_ready),
        .o_data_last  (o_data_last),
        .o_line_end   (o_line_end),
        .o_busy       (o_busy),
        .o_intr       (o_intr)
`ifdef FRAME_OUTPUT_CTRL_FRAME_CNT_EN
        ,
        .o_frame_cnt  (o_frame_cnt)
`endif
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_xfer;
    int         col_m;
    int         row_m;
    int         exp_fcnt;
    logic [9:0] sb_q[$];   // {pixel, line_end, last}

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        col_m = 0;
        row_m = 0;
        sb_q.delete();
    endtask

    // Reference position model: flags derive from the pixel's place in the frame.
    task automatic push_exp(input logic [7:0] d);
        logic le, la;
        le = (col_m == W - 1);
        la = le && (row_m == H - 1);
        sb_q.push_back({d, le, la});
        if (col_m == W - 1) begin
            col_m = 0;
            row_m = (row_m == H - 1) ? 0 : row_m + 1;
        end else begin
            col_m++;
        end
    endtask

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    // Offer one pixel until it transfers; flags are checked every cycle,
    // including stalled ones, to prove they are held.
    task automatic send_pix(input logic [7:0] d, input bit rnd, input bit abort_on_xfer);
        int         guard;
        bit         done;
        logic [9:0] e;
        guard = 0;
        done  = 1'b0;
        push_exp(d);
        i_data_valid = 1'b1;
        i_data       = d;
        while (!done) begin
            i_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_abort      = abort_on_xfer && i_data_ready;
            @(negedge axi_clk);
            check_val("line_end", 32'(o_line_end), 32'(sb_q[0][1]));
            check_val("data_last", 32'(o_data_last), 32'(sb_q[0][0]));
            check_val("ready_pass", 32'(o_data_ready), 32'(i_data_ready));
            if (o_data_valid && i_data_ready) begin
                e = sb_q.pop_front();
                check_val("data", 32'(o_data), 32'(e[9:2]));
                n_xfer++;
                done = 1'b1;
            end
            step();
            i_abort = 1'b0;
            guard++;
            if (!done && guard > 200) begin
                check_val("xfer_timeout", 32'(0), 32'(1));
                sb_q.delete();
                done = 1'b1;
            end
        end
        i_data_valid = 1'b0;
        i_data_ready = 1'b0;
    endtask

    // Called right after the last-pixel edge: DONE cycle then back to IDLE.
    task automatic check_done(input bit start_in_done);
        exp_fcnt = (exp_fcnt + 1) % 65536;
        @(negedge axi_clk);
        check_val("intr_done", 32'(o_intr), 32'(1));
        check_val("busy_done", 32'(o_busy), 32'(0));
`ifdef FRAME_OUTPUT_CTRL_FRAME_CNT_EN
        check_val("frame_cnt", 32'(o_frame_cnt), 32'(exp_fcnt));
`endif
        i_start = start_in_done;
        step();
        i_start = 1'b0;
        @(negedge axi_clk);
        check_val("intr_pulse_end", 32'(o_intr), 32'(0));
        check_val("busy_after", 32'(o_busy), 32'(0));
        step();
        @(negedge axi_clk);
        check_val("busy_idle", 32'(o_busy), 32'(0));
        step();
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge axi_clk);
            check_val({tag, "_intr"}, 32'(o_intr), 32'(0));
            check_val({tag, "_busy"}, 32'(o_busy), 32'(0));
            check_val({tag, "_ready"}, 32'(o_data_ready), 32'(0));
            check_val({tag, "_valid"}, 32'(o_data_valid), 32'(0));
            step();
        end
    endtask

    task automatic run_frame(input logic [7:0] base, input bit rnd);
        pulse_start();
        @(negedge axi_clk);
        check_val("busy_run", 32'(o_busy), 32'(1));
        step();
        n_xfer = 0;
        for (int p = 0; p < W * H; p++) send_pix(base + 8'(p), rnd, 1'b0);
        check_val("xfer_count", 32'(n_xfer), 32'(W * H));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_reset_n  = 1'b0;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_data_valid = 1'b1;
        i_data_ready = 1'b1;
        i_data       = 8'h55;
        exp_fcnt     = 0;
        n_xfer       = 0;
        model_reset();

        // Reset state: every output low even with upstream activity.
        repeat (2) begin
            @(negedge axi_clk);
            check_val("rst_valid", 32'(o_data_valid), 32'(0));
            check_val("rst_ready", 32'(o_data_ready), 32'(0));
            check_val("rst_data", 32'(o_data), 32'(0));
            check_val("rst_busy", 32'(o_busy), 32'(0));
            check_val("rst_intr", 32'(o_intr), 32'(0));
            check_val("rst_last", 32'(o_data_last), 32'(0));
            check_val("rst_line_end", 32'(o_line_end), 32'(0));
`ifdef FRAME_OUTPUT_CTRL_FRAME_CNT_EN
            check_val("rst_frame_cnt", 32'(o_frame_cnt), 32'(0));
`endif
        end
        step();
        axi_reset_n  = 1'b1;
        // Held off in IDLE, and an IDLE abort must do nothing.
        i_abort = 1'b1;
        check_quiet("idle_hold", 2);
        i_abort      = 1'b0;
        i_data_valid = 1'b0;
        i_data_ready = 1'b0;

        // Full-speed frame; a start during DONE is ignored.
        run_frame(8'h10, 1'b0);
        check_done(1'b1);

        // Random downstream stalls over the same frame.
        run_frame(8'h10, 1'b1);
        check_done(1'b0);

        // Abort after 5 transfers: no interrupt, counters restart.
        pulse_start();
        for (int p = 0; p < 5; p++) send_pix(8'h20 + 8'(p), 1'b0, 1'b0);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        model_reset();
        check_quiet("abort", 3);
        run_frame(8'h30, 1'b0);
        check_done(1'b0);

        // Abort coincident with the last transfer: completion wins.
        pulse_start();
        for (int p = 0; p < W * H - 1; p++) send_pix(8'h40 + 8'(p), 1'b0, 1'b0);
        send_pix(8'h47, 1'b0, 1'b1);
        check_done(1'b0);

        // Start request inside RUN after 2 transfers is ignored.
        pulse_start();
        n_xfer = 0;
        for (int p = 0; p < 2; p++) send_pix(8'h50 + 8'(p), 1'b0, 1'b0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        @(negedge axi_clk);
        check_val("start_in_run_busy", 32'(o_busy), 32'(1));
        step();
        for (int p = 2; p < W * H; p++) send_pix(8'h50 + 8'(p), 1'b0, 1'b0);
        check_val("start_in_run_xfers", 32'(n_xfer), 32'(W * H));
        check_done(1'b0);

        // Asynchronous reset mid-frame after 3 transfers.
        pulse_start();
        for (int p = 0; p < 3; p++) send_pix(8'h60 + 8'(p), 1'b0, 1'b0);
        i_data_valid = 1'b1;
        i_data_ready = 1'b1;
        i_data       = 8'hAA;
        #2;
        axi_reset_n = 1'b0;
        #1;
        check_val("arst_valid", 32'(o_data_valid), 32'(0));
        check_val("arst_ready", 32'(o_data_ready), 32'(0));
        check_val("arst_data", 32'(o_data), 32'(0));
        check_val("arst_busy", 32'(o_busy), 32'(0));
        check_val("arst_line_end", 32'(o_line_end), 32'(0));
        exp_fcnt = 0;
`ifdef FRAME_OUTPUT_CTRL_FRAME_CNT_EN
        check_val("arst_frame_cnt", 32'(o_frame_cnt), 32'(0));
`endif
        step();
        axi_reset_n = 1'b1;
        model_reset();
        check_quiet("post_rst", 4);
        i_data_valid = 1'b0;
        i_data_ready = 1'b0;

        // Fresh frame after reset starts at column 0.
        run_frame(8'h70, 1'b1);
        check_done(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_frame_output_ctrl
